// File: rtl/instruction_fetcher_pkg.sv
// Shared encodings for the core pipeline, the fetch stage and the decoder.
// Also holds the saturating increment used by the fetch performance counters.
package instruction_fetcher_pkg;

    localparam int PROGRAM_MEM_ADDR_BITS = 8;
    localparam int PROGRAM_MEM_DATA_BITS = 16;
    localparam int FETCH_CACHE_ENTRIES   = 4;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_e;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_e;

    // Opcode field (instruction[15:12]) values shared with the decoder.
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_BRNZP = 4'b0001;
    localparam logic [3:0] OP_CMP   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0101;
    localparam logic [3:0] OP_DIV   = 4'b0110;
    localparam logic [3:0] OP_LDR   = 4'b0111;
    localparam logic [3:0] OP_STR   = 4'b1000;
    localparam logic [3:0] OP_CONST = 4'b1001;
    localparam logic [3:0] OP_RET   = 4'b1111;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/instruction_fetcher_cache_array.sv
// Direct-mapped instruction cache storage: combinational lookup, one fill port,
// and a flash invalidate that takes priority over a fill in the same cycle.
module instruction_fetcher_cache_array
    import instruction_fetcher_pkg::*;
#(
    parameter int ENTRIES   = FETCH_CACHE_ENTRIES,
    parameter int DATA_BITS = PROGRAM_MEM_DATA_BITS,
    parameter int IDX_BITS  = $clog2(ENTRIES),
    parameter int TAG_BITS  = PROGRAM_MEM_ADDR_BITS - IDX_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_BITS-1:0]  lookup_idx,
    input  logic [TAG_BITS-1:0]  lookup_tag,
    output logic                 lookup_hit,
    output logic [DATA_BITS-1:0] lookup_data,
    input  logic                 fill_en,
    input  logic [IDX_BITS-1:0]  fill_idx,
    input  logic [TAG_BITS-1:0]  fill_tag,
    input  logic [DATA_BITS-1:0] fill_data,
    input  logic                 invalidate
);

    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q  [ENTRIES];
    logic [TAG_BITS-1:0]  tag_d  [ENTRIES];
    logic [DATA_BITS-1:0] data_q [ENTRIES];
    logic [DATA_BITS-1:0] data_d [ENTRIES];

    assign lookup_hit  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign lookup_data = data_q[lookup_idx];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en && !invalidate) begin
            valid_d[fill_idx] = 1'b1;
            tag_d[fill_idx]   = fill_tag;
            data_d[fill_idx]  = fill_data;
        end
        if (invalidate) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/instruction_fetcher.sv
// Per-core instruction fetch stage: serves FETCH from a small direct-mapped cache,
// falls back to a valid/ready read of program memory, and counts hits and misses.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_ENTRIES         = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             invalidate,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);

    localparam int IDX_BITS = $clog2(CACHE_ENTRIES);
    localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

    fetcher_state_e                   state_q, state_d;
    logic                             mem_read_valid_q, mem_read_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address_q, mem_read_address_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instruction_q, instruction_d;
    logic [15:0]                      hit_count_q, hit_count_d;
    logic [15:0]                      miss_count_q, miss_count_d;

    logic                             lookup_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] lookup_data;
    logic                             fill_en;

    wire fetch_request = (state_q == FETCHER_IDLE) && (core_state == CORE_FETCH);

    // The fill address is the latched request address, not current_pc.
    instruction_fetcher_cache_array #(
        .ENTRIES   (CACHE_ENTRIES),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .IDX_BITS  (IDX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_cache (
        .clk         (clk),
        .reset       (reset),
        .lookup_idx  (current_pc[IDX_BITS-1:0]),
        .lookup_tag  (current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS]),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .fill_en     (fill_en),
        .fill_idx    (mem_read_address_q[IDX_BITS-1:0]),
        .fill_tag    (mem_read_address_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS]),
        .fill_data   (mem_read_data),
        .invalidate  (invalidate)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= FETCHER_IDLE;
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= '0;
            instruction_q      <= '0;
            hit_count_q        <= '0;
            miss_count_q       <= '0;
        end else begin
            state_q            <= state_d;
            mem_read_valid_q   <= mem_read_valid_d;
            mem_read_address_q <= mem_read_address_d;
            instruction_q      <= instruction_d;
            hit_count_q        <= hit_count_d;
            miss_count_q       <= miss_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCHER_IDLE:     if (fetch_request) state_d = lookup_hit ? FETCHER_FETCHED : FETCHER_FETCHING;
            FETCHER_FETCHING: if (mem_read_ready) state_d = FETCHER_FETCHED;
            FETCHER_FETCHED:  if (core_state == CORE_DECODE) state_d = FETCHER_IDLE;
            default:          state_d = FETCHER_IDLE;
        endcase
    end

    always_comb begin
        mem_read_valid_d   = mem_read_valid_q;
        mem_read_address_d = mem_read_address_q;
        instruction_d      = instruction_q;
        hit_count_d        = hit_count_q;
        miss_count_d       = miss_count_q;
        fill_en            = 1'b0;
        if (fetch_request) begin
            if (lookup_hit) begin
                instruction_d = lookup_data;
                hit_count_d   = sat_inc16(hit_count_q);
            end else begin
                mem_read_valid_d   = 1'b1;
                mem_read_address_d = current_pc;
                miss_count_d       = sat_inc16(miss_count_q);
            end
        end else if ((state_q == FETCHER_FETCHING) && mem_read_ready) begin
            instruction_d    = mem_read_data;
            mem_read_valid_d = 1'b0;
            fill_en          = 1'b1;
        end
    end

    assign mem_read_valid   = mem_read_valid_q;
    assign mem_read_address = mem_read_address_q;
    assign fetcher_state    = state_q;
    assign instruction      = instruction_q;
    assign hit_count        = hit_count_q;
    assign miss_count       = miss_count_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Randomized self-checking bench for instruction_fetcher against a behavioural
// model of the cache (per-index last installed PC/data) and the fetch protocol.
module tb_instruction_fetcher;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  core_state;
   logic [7:0]  current_pc;
   logic        invalidate;
   logic        mem_read_valid;
   logic [7:0]  mem_read_address;
   logic        mem_read_ready;
   logic [15:0] mem_read_data;
   logic [2:0]  fetcher_state;
   logic [15:0] instruction;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   localparam logic [2:0] CS_FETCH  = 3'b001;
   localparam logic [2:0] CS_DECODE = 3'b010;
   localparam logic [2:0] FS_IDLE     = 3'b000;
   localparam logic [2:0] FS_FETCHING = 3'b001;
   localparam logic [2:0] FS_FETCHED  = 3'b010;

   always #5 clk = ~clk;

   instruction_fetcher dut (
      .clk              (clk),
      .reset            (reset),
      .core_state       (core_state),
      .current_pc       (current_pc),
      .invalidate       (invalidate),
      .mem_read_valid   (mem_read_valid),
      .mem_read_address (mem_read_address),
      .mem_read_ready   (mem_read_ready),
      .mem_read_data    (mem_read_data),
      .fetcher_state    (fetcher_state),
      .instruction      (instruction),
      .hit_count        (hit_count),
      .miss_count       (miss_count)
   );

   int          vecCount = 0;
   int          errCount = 0;
   logic [15:0] progMem [256];
   bit          modelValid [4];
   logic [7:0]  modelPc [4];
   logic [15:0] modelData [4];
   int          modelHits;
   int          modelMisses;
   logic [15:0] modelInstr;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: observed %h, expected %h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [15:0] satValue(input int v);
      logic [31:0] w;
      w = v;
      return (v > 65535) ? 16'hFFFF : w[15:0];
   endfunction

   // Drive one cycle of inputs, let one rising edge pass, return just after it.
   task automatic applyStimulus(input logic [2:0] cs, input logic [7:0] pc, input logic rdy,
                                input logic [15:0] rdata, input logic inv);
      core_state     = cs;
      current_pc     = pc;
      mem_read_ready = rdy;
      mem_read_data  = rdata;
      invalidate     = inv;
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 4; i++) modelValid[i] = 1'b0;
      modelHits   = 0;
      modelMisses = 0;
      modelInstr  = 16'h0000;
   endtask

   task automatic modelInvalidate();
      for (int i = 0; i < 4; i++) modelValid[i] = 1'b0;
   endtask

   task automatic checkCounters();
      checkOutput("hit_count", {16'h0, hit_count}, {16'h0, satValue(modelHits)});
      checkOutput("miss_count", {16'h0, miss_count}, {16'h0, satValue(modelMisses)});
   endtask

   function automatic logic [2:0] randNonFetch();
      logic [2:0] v;
      v = 3'($urandom_range(0, 6));
      if (v >= 3'd1) v = v + 3'd1;
      return v;
   endfunction

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(randNonFetch(), 8'($urandom), 1'($urandom), 16'($urandom), 1'b0);
         checkOutput("idle_state", {29'h0, fetcher_state}, {29'h0, FS_IDLE});
         checkOutput("idle_valid", {31'h0, mem_read_valid}, 32'h0);
         checkOutput("idle_instr", {16'h0, instruction}, {16'h0, modelInstr});
      end
   endtask

   // One complete FETCH .. FETCHED .. DECODE round trip for a given PC.
   task automatic fetchPc(input logic [7:0] pc, input int waitCycles, input bit invFetch,
                          input bit invFill, input int holdCycles);
      int idx;
      bit hit;
      logic [2:0] cs;
      idx = int'(pc[1:0]);
      hit = modelValid[idx] && (modelPc[idx] == pc);
      applyStimulus(CS_FETCH, pc, 1'b0, 16'h0, invFetch);
      if (invFetch) modelInvalidate();
      if (hit) begin
         modelHits++;
         modelInstr = modelData[idx];
         checkOutput("hit_state", {29'h0, fetcher_state}, {29'h0, FS_FETCHED});
         checkOutput("hit_instr", {16'h0, instruction}, {16'h0, modelInstr});
         checkOutput("hit_no_req", {31'h0, mem_read_valid}, 32'h0);
      end else begin
         modelMisses++;
         checkOutput("miss_state", {29'h0, fetcher_state}, {29'h0, FS_FETCHING});
         checkOutput("miss_valid", {31'h0, mem_read_valid}, 32'h1);
         checkOutput("miss_addr", {24'h0, mem_read_address}, {24'h0, pc});
         for (int w = 0; w < waitCycles; w++) begin
            applyStimulus(CS_FETCH, pc, 1'b0, 16'($urandom), 1'b0);
            checkOutput("wait_valid", {31'h0, mem_read_valid}, 32'h1);
            checkOutput("wait_addr", {24'h0, mem_read_address}, {24'h0, pc});
            checkOutput("wait_state", {29'h0, fetcher_state}, {29'h0, FS_FETCHING});
         end
         applyStimulus(CS_FETCH, pc, 1'b1, progMem[pc], invFill);
         modelInstr = progMem[pc];
         checkOutput("fill_state", {29'h0, fetcher_state}, {29'h0, FS_FETCHED});
         checkOutput("fill_instr", {16'h0, instruction}, {16'h0, modelInstr});
         checkOutput("fill_valid", {31'h0, mem_read_valid}, 32'h0);
         if (invFill) modelInvalidate();
         else begin
            modelValid[idx] = 1'b1;
            modelPc[idx]    = pc;
            modelData[idx]  = progMem[pc];
         end
      end
      checkCounters();
      for (int h = 0; h < holdCycles; h++) begin
         cs = 3'($urandom);
         if (cs == CS_DECODE) cs = CS_FETCH;
         applyStimulus(cs, 8'($urandom), 1'($urandom), 16'($urandom), 1'b0);
         checkOutput("hold_state", {29'h0, fetcher_state}, {29'h0, FS_FETCHED});
         checkOutput("hold_instr", {16'h0, instruction}, {16'h0, modelInstr});
         checkOutput("hold_valid", {31'h0, mem_read_valid}, 32'h0);
      end
      applyStimulus(CS_DECODE, pc, 1'($urandom), 16'($urandom), 1'b0);
      checkOutput("decode_state", {29'h0, fetcher_state}, {29'h0, FS_IDLE});
      checkOutput("decode_instr", {16'h0, instruction}, {16'h0, modelInstr});
   endtask

   initial begin
      reset          = 1'b1;
      core_state     = 3'b000;
      current_pc     = 8'h00;
      invalidate     = 1'b0;
      mem_read_ready = 1'b0;
      mem_read_data  = 16'h0000;
      for (int i = 0; i < 256; i++) progMem[i] = 16'($urandom);
      progMem[8'h05] = 16'h3123;
      progMem[8'h01] = 16'h9A05;
      progMem[8'h22] = 16'hA012;
      modelReset();

      applyStimulus(3'b000, 8'h00, 1'b0, 16'h0, 1'b0);
      applyStimulus(CS_FETCH, 8'h05, 1'b1, 16'hFFFF, 1'b0);
      checkOutput("reset_state", {29'h0, fetcher_state}, {29'h0, FS_IDLE});
      checkOutput("reset_valid", {31'h0, mem_read_valid}, 32'h0);
      checkOutput("reset_addr", {24'h0, mem_read_address}, 32'h0);
      checkOutput("reset_instr", {16'h0, instruction}, 32'h0);
      checkCounters();
      reset = 1'b0;

      // Cold miss, hit, conflict eviction
      fetchPc(8'h05, 2, 1'b0, 1'b0, 0);
      fetchPc(8'h05, 0, 1'b0, 1'b0, 1);
      fetchPc(8'h01, 1, 1'b0, 1'b0, 0);
      fetchPc(8'h05, 0, 1'b0, 1'b0, 0);
      fetchPc(8'h01, 3, 1'b0, 1'b0, 0);

      // Invalidate racing a fill, then racing a hit lookup
      fetchPc(8'h22, 1, 1'b0, 1'b1, 0);
      fetchPc(8'h22, 0, 1'b0, 1'b0, 0);
      fetchPc(8'h22, 0, 1'b1, 1'b0, 0);
      fetchPc(8'h22, 0, 1'b0, 1'b0, 0);

      for (int n = 0; n < 300; n++) begin
         idleCycles($urandom_range(0, 2));
         fetchPc(8'($urandom_range(0, 15)), $urandom_range(0, 3),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), $urandom_range(0, 2));
      end

      // Reset while a request is outstanding
      fetchPc(8'h05, 0, 1'b0, 1'b0, 0);
      applyStimulus(CS_FETCH, 8'h47, 1'b0, 16'h0, 1'b0);
      checkOutput("pre_reset_valid", {31'h0, mem_read_valid}, {31'h0, !(modelValid[3] && modelPc[3] == 8'h47)});
      reset = 1'b1;
      applyStimulus(CS_FETCH, 8'h47, 1'b0, 16'h0, 1'b0);
      modelReset();
      checkOutput("rst_mid_valid", {31'h0, mem_read_valid}, 32'h0);
      checkOutput("rst_mid_state", {29'h0, fetcher_state}, {29'h0, FS_IDLE});
      checkOutput("rst_mid_instr", {16'h0, instruction}, 32'h0);
      checkCounters();
      reset = 1'b0;
      fetchPc(8'h05, 1, 1'b0, 1'b0, 0);
      checkOutput("rst_lines_invalid", {16'h0, miss_count}, 32'h1);

      // Saturation: preload the hit counter near the top, then keep hitting
      force dut.hit_count_q = 16'hFFFD;
      #1;
      release dut.hit_count_q;
      modelHits = 65533;
      for (int s = 0; s < 5; s++) fetchPc(8'h05, 0, 1'b0, 1'b0, 0);
      checkOutput("hit_saturated", {16'h0, hit_count}, 32'h0000FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
